dbg_scan_ctrl: RTL
==================

Name: dbg_scan_ctrl

Overview:
Sequencer for the CPU debug readout path: DataOrReg select, 5-bit address, 2-bit vout_addr byte select, 8-bit value_o.
- Walks an address range of the register file or data memory.
- Steps vout_addr through all byte slices and assembles each 32-bit word.
- Presents each word on a valid/ready stream so an off-chip or UART dumper can drain CPU state without manual switch toggling.
- Sits beside the CPU instance and drives its debug inputs in place of board switches.

Parameters:
ADDR_W, 5, width of debug address.
NUM_SLICES, 4, bytes per word; vout_addr_o width fixed at 2.
SETTLE_CYC, 1, extra cycles address/vout_addr are held before value_i is sampled. Legal range 0..15.

Ports:
clk_i  in  1  clock, single domain (CPU clock).
reset  in  1  synchronous, active-low reset.
start_i  in  1  begin a scan; sampled only in IDLE.
abort_i  in  1  terminate scan; return to IDLE next cycle.
mode_i  in  1  0 = register file, 1 = data memory; latched at start.
first_addr_i  in  ADDR_W  first address; latched at start.
last_addr_i  in  ADDR_W  last address, inclusive; latched at start.
DataOrReg_o  out  1  to CPU DataOrReg.
address_o  out  ADDR_W  to CPU address.
vout_addr_o  out  2  to CPU vout_addr.
value_i  in  8  from CPU value_o.
word_o  out  32  assembled word; slice 0 in [7:0], slice 3 in [31:24].
word_addr_o  out  ADDR_W  address of word_o.
word_valid_o  out  1  word_o valid.
word_ready_i  in  1  consumer accepts word.
busy_o  out  1  high in any state except IDLE.
done_o  out  1  one-cycle pulse when the scan completes normally.

Behaviour:
- Reset (reset=0 at a clk_i edge): state IDLE.
  - All outputs 0: DataOrReg_o, address_o, vout_addr_o, word_o, word_addr_o, word_valid_o, busy_o, done_o.
  - Internal slice and settle counters cleared.
- States: IDLE, SETTLE, CAPTURE, EMIT, DONE.
- IDLE:
  - On start_i=1: latch mode_i, first/last addresses; address_o<=first_addr_i; vout_addr_o<=0; DataOrReg_o<=mode_i; go to SETTLE.
  - start_i in any other state is ignored.
- SETTLE: hold outputs for SETTLE_CYC cycles. Counter counts 0..SETTLE_CYC-1. SETTLE_CYC=0 skips straight to CAPTURE.
- CAPTURE (1 cycle): write value_i into byte slot vout_addr_o of the word shift register.
  - If vout_addr_o < 3: vout_addr_o+1, go to SETTLE.
  - Else: go to EMIT with word_valid_o=1, word_addr_o=address_o.
- Per-slice latency is SETTLE_CYC+1 cycles. With SETTLE_CYC=1: start seen at edge 0, first word_valid_o high after edge 8.
- EMIT: word_o and word_addr_o are stable while word_valid_o=1 and word_ready_i=0.
  - On word_valid_o & word_ready_i: drop word_valid_o.
  - If address_o == latched last: go to DONE.
  - Else: address_o+1 (mod 2^ADDR_W), vout_addr_o<=0, go to SETTLE.
- Wrap: if first > last, the scan wraps 31→0 and continues to last. If first == last, exactly one word is produced.
- DONE (1 cycle): done_o=1, then IDLE. address_o, vout_addr_o and DataOrReg_o keep their last values in IDLE.
- abort_i (any non-IDLE state, priority over all transitions): next state IDLE, word_valid_o=0, no done_o pulse. A partially assembled word is discarded.
- abort_i and word_ready_i in the same EMIT cycle: the handshake counts (word consumed), then abort takes effect.
- Reset mid-scan: immediate return to reset values. No pending word survives.
- busy_o=1 in SETTLE, CAPTURE, EMIT and DONE.

Optional Feature:
DBG_SCAN_SKIP_ZERO_EN
- Defined: in CAPTURE of slice 3, if the assembled word equals 32'h0, EMIT is bypassed (no word_valid_o). The address advance/DONE decision is made directly, as if the word had been accepted. done_o behaviour is unchanged.
- Undefined: every address in range produces a word, including zero words.

Test Plan:
- Reg scan, first=0, last=3, SETTLE_CYC=1, ready tied 1, value_i modelled as {addr,slice}-derived bytes.
  -> 4 words, addresses 0..3; first valid 8 cycles after start; done_o one pulse; busy_o low afterwards.
- Data scan, mode_i=1, first=last=7, value_i returns 8'hEF,8'hBE,8'hAD,8'hDE for vout 0..3.
  -> DataOrReg_o=1; one word 32'hDEADBEEF at word_addr_o=7.
- Backpressure: word_ready_i held 0 for 5 cycles in EMIT.
  -> word_o/word_addr_o/word_valid_o stable; address_o unchanged until the handshake.
- Wrap: first=30, last=1.
  -> word_addr_o sequence 30,31,0,1; then done_o.
- abort_i asserted during slice 2 of address 5.
  -> IDLE next cycle; no word for address 5; no done_o. A new start_i is accepted immediately after.
- Reset mid-EMIT (reset=0 one edge).
  -> all outputs 0 next cycle. With DBG_SCAN_SKIP_ZERO_EN: range containing zero words 2,3 yields no words for those addresses.

Source files
------------

// File: rtl/dbg_scan_ctrl.sv
// Debug readout sequencer: walks reg-file/data-memory addresses, assembles 32-bit words byte by byte.
// Optional DBG_SCAN_SKIP_ZERO_EN suppresses all-zero words; each slice takes SETTLE_CYC+1 cycles.
module dbg_scan_ctrl #(
  parameter int ADDR_W     = 5,
  parameter int NUM_SLICES = 4,
  parameter int SETTLE_CYC = 1
) (
  input  logic              clk_i,
  input  logic              reset,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              mode_i,
  input  logic [ADDR_W-1:0] first_addr_i,
  input  logic [ADDR_W-1:0] last_addr_i,
  output logic              DataOrReg_o,
  output logic [ADDR_W-1:0] address_o,
  output logic [1:0]        vout_addr_o,
  input  logic [7:0]        value_i,
  output logic [31:0]       word_o,
  output logic [ADDR_W-1:0] word_addr_o,
  output logic              word_valid_o,
  input  logic              word_ready_i,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_EMIT,
    S_DONE
  } state_t;

  localparam logic [1:0] LAST_SLICE  = 2'(NUM_SLICES - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_t              state_q, state_d;
  logic                dor_q, dor_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [1:0]          vout_q, vout_d;
  logic [31:0]         word_q, word_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [3:0]          settle_q, settle_d;
  logic                advance;

  // With no settle time the address phase collapses straight into capture.
  function automatic state_t load_state();
    if (SETTLE_CYC == 0) return S_CAPTURE;
    else                 return S_SETTLE;
  endfunction

  always_comb begin
    state_d  = state_q;
    dor_d    = dor_q;
    addr_d   = addr_q;
    last_d   = last_q;
    vout_d   = vout_q;
    word_d   = word_q;
    waddr_d  = waddr_q;
    settle_d = settle_q;
    advance  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          dor_d    = mode_i;
          addr_d   = first_addr_i;
          last_d   = last_addr_i;
          vout_d   = 2'd0;
          settle_d = 4'd0;
          state_d  = load_state();
        end
      end
      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = 4'd0;
          state_d  = S_CAPTURE;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      S_CAPTURE: begin
        word_d[{vout_q, 3'b000} +: 8] = value_i;
        if (vout_q != LAST_SLICE) begin
          vout_d  = vout_q + 2'd1;
          state_d = load_state();
        end else begin
          waddr_d = addr_q;
`ifdef DBG_SCAN_SKIP_ZERO_EN
          if (word_d == 32'h0) advance = 1'b1;
          else                 state_d = S_EMIT;
`else
          state_d = S_EMIT;
`endif
        end
      end
      S_EMIT: begin
        if (word_ready_i) advance = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Word finished (accepted or skipped): end of range or next address.
    if (advance) begin
      if (addr_q == last_q) begin
        state_d = S_DONE;
      end else begin
        addr_d  = addr_q + ADDR_W'(1);
        vout_d  = 2'd0;
        state_d = load_state();
      end
    end

    // Abort wins over every transition; the CPU-facing outputs freeze where they are.
    if (abort_i && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      settle_d = 4'd0;
      addr_d   = addr_q;
      vout_d   = vout_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      dor_q    <= 1'b0;
      addr_q   <= '0;
      last_q   <= '0;
      vout_q   <= 2'd0;
      word_q   <= 32'h0;
      waddr_q  <= '0;
      settle_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      dor_q    <= dor_d;
      addr_q   <= addr_d;
      last_q   <= last_d;
      vout_q   <= vout_d;
      word_q   <= word_d;
      waddr_q  <= waddr_d;
      settle_q <= settle_d;
    end
  end

  assign DataOrReg_o  = dor_q;
  assign address_o    = addr_q;
  assign vout_addr_o  = vout_q;
  assign word_o       = word_q;
  assign word_addr_o  = waddr_q;
  assign word_valid_o = (state_q == S_EMIT);
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);

endmodule
